// File: rtl/imersiv_avl_image_responder_if.sv
// ----------------------------------------------------------------------------
// imersiv_avl_image_responder_if
// Avalon-MM bus bundle between the host fabric and the image responder.
//   AVL_CS        chip select (master -> slave)
//   AVL_READ      read strobe, qualified by AVL_CS (master -> slave)
//   AVL_WRITE     write strobe, qualified by AVL_CS (master -> slave)
//   AVL_ADDR      5-bit word address (master -> slave)
//   AVL_WRITEDATA 32-bit write data (master -> slave)
//   AVL_READDATA  32-bit read data (slave -> master)
// ----------------------------------------------------------------------------
interface imersiv_avl_image_responder_if;
  logic        AVL_CS;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic [4:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/imersiv_avl_image_responder.sv
// ----------------------------------------------------------------------------
// imersiv_avl_image_responder
// Avalon-MM responder that collects a binarised image as one write per row,
// offers the packed image to the inference core, latches the class result and
// raises CHARACTER_IRQ. Reads return data a fixed READ_LATENCY edges after
// the read is sampled.
//
// Ports:
//   CLK            system clock, rising edge
//   RESET_N        asynchronous active-low reset
//   avl            Avalon-MM slave bundle (CS/READ/WRITE/ADDR/WRITEDATA/READDATA)
//   IMG_DATA       packed image, row i at [ROW_WIDTH*i +: ROW_WIDTH]
//   IMG_VALID      image offer to the core
//   IMG_READY      core accepts the image
//   CORE_DONE      one-cycle pulse, CORE_CLASS valid
//   CORE_CLASS     detected class
//   CHARACTER_IRQ  level interrupt, result available
//
// Address map: 0x00..NUM_ROWS-1 rows, 0x1C result (RO),
//   0x1D status {overrun, irq, busy, mask_full} / control (bit1 clear IRQ,
//   bit2 clear overrun, bit0 start when soft start is built in), others read 0.
//
// Build option: define IMERSIV_SOFT_START_EN to replace auto-start with an
// explicit start (0x1D bit0) that requires a full row mask.
// ----------------------------------------------------------------------------
module imersiv_avl_image_responder #(
  parameter int NUM_ROWS     = 28,
  parameter int ROW_WIDTH    = 28,
  parameter int CLASS_WIDTH  = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  imersiv_avl_image_responder_if.slave      avl,
  output logic [NUM_ROWS*ROW_WIDTH-1:0]     IMG_DATA,
  output logic                              IMG_VALID,
  input  logic                              IMG_READY,
  input  logic                              CORE_DONE,
  input  logic [CLASS_WIDTH-1:0]            CORE_CLASS,
  output logic                              CHARACTER_IRQ
);

  localparam int IMG_W = NUM_ROWS * ROW_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [4:0] ADDR_RESULT = 5'h1C;
  localparam logic [4:0] ADDR_STATUS = 5'h1D;
  localparam logic [4:0] ROW_END     = 5'(NUM_ROWS);

  logic [1:0]             state_q, state_d;
  logic [IMG_W-1:0]       img_q, img_d;
  logic [NUM_ROWS-1:0]    mask_q, mask_d;
  logic                   img_valid_q, img_valid_d;
  logic                   irq_q, irq_d;
  logic                   ovr_q, ovr_d;
  logic [CLASS_WIDTH-1:0] result_q, result_d;

  logic [READ_LATENCY-1:0]        pipe_vld_q;
  logic [READ_LATENCY-1:0][31:0]  pipe_data_q;
  logic [31:0]                    rdata_q;

  logic        wr_s, rd_s, row_hit_s, busy_s, mask_full_s;
  logic        irq_set_s, irq_clr_s, ovr_set_s, ovr_clr_s;
  logic [31:0] row_value_s, rd_value_s;
  logic        unused_wdata_s;

  // A simultaneous write takes priority, so the read is dropped.
  assign wr_s        = avl.AVL_CS & avl.AVL_WRITE;
  assign rd_s        = avl.AVL_CS & avl.AVL_READ & ~avl.AVL_WRITE;
  assign row_hit_s   = (avl.AVL_ADDR < ROW_END);
  assign busy_s      = (state_q == ST_REQ) | (state_q == ST_RUN);
  assign mask_full_s = &mask_q;

  assign unused_wdata_s = ^avl.AVL_WRITEDATA[31:ROW_WIDTH];

  assign IMG_DATA          = img_q;
  assign IMG_VALID         = img_valid_q;
  assign CHARACTER_IRQ     = irq_q;
  assign avl.AVL_READDATA  = rdata_q;

  // Read-data mux over pre-edge register state.
  always_comb begin
    row_value_s = 32'h0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      row_value_s = (avl.AVL_ADDR == 5'(i)) ? 32'(img_q[i*ROW_WIDTH +: ROW_WIDTH]) : row_value_s;
    end
    case (avl.AVL_ADDR)
      ADDR_RESULT: rd_value_s = 32'(result_q);
      ADDR_STATUS: rd_value_s = {28'h0, ovr_q, irq_q, busy_s, mask_full_s};
      default:     rd_value_s = row_value_s;  // rows, and 0 above the row range
    endcase
  end

  // Register writes, FSM next state, IRQ and overrun flags.
  always_comb begin
    state_d     = state_q;
    img_d       = img_q;
    mask_d      = mask_q;
    img_valid_d = img_valid_q;
    result_d    = result_q;
    irq_set_s   = 1'b0;
    irq_clr_s   = 1'b0;
    ovr_set_s   = 1'b0;
    ovr_clr_s   = 1'b0;

    if (wr_s && row_hit_s) begin
      if (busy_s) begin
        // Keep IMG_DATA frozen while the core owns it.
        ovr_set_s = 1'b1;
      end else begin
        for (int i = 0; i < NUM_ROWS; i++) begin
          if (avl.AVL_ADDR == 5'(i)) begin
            img_d[i*ROW_WIDTH +: ROW_WIDTH] = avl.AVL_WRITEDATA[ROW_WIDTH-1:0];
            mask_d[i] = 1'b1;
          end else begin
            mask_d[i] = mask_q[i];
          end
        end
      end
    end else if (wr_s && (avl.AVL_ADDR == ADDR_STATUS)) begin
      irq_clr_s = avl.AVL_WRITEDATA[1];
      ovr_clr_s = avl.AVL_WRITEDATA[2];
    end else if (rd_s && (avl.AVL_ADDR == ADDR_RESULT)) begin
      irq_clr_s = 1'b1;
    end else begin
      irq_clr_s = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
`ifdef IMERSIV_SOFT_START_EN
        if (wr_s && (avl.AVL_ADDR == ADDR_STATUS) && avl.AVL_WRITEDATA[0]) begin
          if (mask_full_s) begin
            state_d     = ST_REQ;
            img_valid_d = 1'b1;
            mask_d      = '0;
          end else begin
            ovr_set_s = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
`else
        // Auto-start on the edge that completes the mask.
        if (&mask_d) begin
          state_d     = ST_REQ;
          img_valid_d = 1'b1;
          mask_d      = '0;
        end else begin
          state_d = state_q;
        end
`endif
      end
      ST_REQ: begin
        if (img_valid_q && IMG_READY) begin
          state_d     = ST_RUN;
          img_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (CORE_DONE) begin
          result_d  = CORE_CLASS;
          irq_set_s = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        img_valid_d = 1'b0;
      end
    endcase

    // Set beats clear when both land on the same edge.
    irq_d = irq_set_s ? 1'b1 : (irq_clr_s ? 1'b0 : irq_q);
    ovr_d = ovr_set_s ? 1'b1 : (ovr_clr_s ? 1'b0 : ovr_q);
  end

  // Control/image state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      img_q       <= '0;
      mask_q      <= '0;
      img_valid_q <= 1'b0;
      irq_q       <= 1'b0;
      ovr_q       <= 1'b0;
      result_q    <= {CLASS_WIDTH{1'b1}};
    end else begin
      state_q     <= state_d;
      img_q       <= img_d;
      mask_q      <= mask_d;
      img_valid_q <= img_valid_d;
      irq_q       <= irq_d;
      ovr_q       <= ovr_d;
      result_q    <= result_d;
    end
  end

  // Read pipeline: capture at the sample edge, present READ_LATENCY edges later.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pipe_vld_q  <= '0;
      pipe_data_q <= '0;
      rdata_q     <= 32'h0;
    end else begin
      pipe_vld_q[0]  <= rd_s;
      pipe_data_q[0] <= rd_value_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
      if (pipe_vld_q[READ_LATENCY-1]) begin
        rdata_q <= pipe_data_q[READ_LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_imersiv_avl_image_responder.sv
// ----------------------------------------------------------------------------
// Testbench for imersiv_avl_image_responder. A behavioural model (row array,
// written-row set, phase, flags and a queue of pending read results) is
// stepped on every rising edge; the DUT outputs are compared against it on
// every falling edge, alongside hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_imersiv_avl_image_responder;

  localparam int NR = 28;

  localparam int PH_IDLE  = 0;
  localparam int PH_OFFER = 1;
  localparam int PH_INFER = 2;
  localparam int PH_DONE  = 3;

  typedef struct {
    logic [31:0] d;
    int          due;
  } rd_t;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         IMG_READY = 1'b0;
  logic         CORE_DONE = 1'b0;
  logic [3:0]   CORE_CLASS = 4'h0;
  logic [783:0] IMG_DATA;
  logic         IMG_VALID;
  logic         CHARACTER_IRQ;

  imersiv_avl_image_responder_if avl();

  imersiv_avl_image_responder dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .avl           (avl.slave),
    .IMG_DATA      (IMG_DATA),
    .IMG_VALID     (IMG_VALID),
    .IMG_READY     (IMG_READY),
    .CORE_DONE     (CORE_DONE),
    .CORE_CLASS    (CORE_CLASS),
    .CHARACTER_IRQ (CHARACTER_IRQ)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cycles = 0;

  // model state
  logic [27:0] m_rows [NR];
  bit          m_written [NR];
  int          m_phase;
  bit          m_irq, m_ovr;
  logic [3:0]  m_result;
  logic [31:0] m_rdata;
  int          m_cyc;
  rd_t         rq[$];

  function automatic bit m_full();
    int n = 0;
    for (int i = 0; i < NR; i++) n += m_written[i] ? 1 : 0;
    return n == NR;
  endfunction

  function automatic bit m_busy();
    return (m_phase == PH_OFFER) || (m_phase == PH_INFER);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a < 5'd28) return {4'h0, m_rows[a]};
    if (a == 5'h1C) return {28'h0, m_result};
    if (a == 5'h1D) return {28'h0, m_ovr, m_irq, m_busy(), m_full()};
    return 32'h0;
  endfunction

  function automatic logic [783:0] m_img();
    logic [783:0] v = '0;
    for (int i = 0; i < NR; i++) v[28*i +: 28] = m_rows[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      m_rows[i] = 28'h0;
      m_written[i] = 1'b0;
    end
    m_phase = PH_IDLE;
    m_irq = 1'b0;
    m_ovr = 1'b0;
    m_result = 4'hF;
    m_rdata = 32'h0;
    m_cyc = 0;
    rq.delete();
  endtask

  // One rising edge of the model, using the inputs as sampled at that edge.
  task automatic m_step();
    logic [4:0]  a;
    logic [31:0] d;
    bit wr, rd, irq_clr, irq_set, ovr_clr, ovr_set;
`ifdef IMERSIV_SOFT_START_EN
    bit start;
`endif
    rd_t ent;
    if (!RESET_N) begin
      m_reset();
      return;
    end
    m_cyc++;
    if (rq.size() > 0 && rq[0].due == m_cyc) begin
      ent = rq.pop_front();
      m_rdata = ent.d;
    end
    a = avl.AVL_ADDR;
    d = avl.AVL_WRITEDATA;
    wr = avl.AVL_CS && avl.AVL_WRITE;
    rd = avl.AVL_CS && avl.AVL_READ && !wr;
    irq_clr = 0; irq_set = 0; ovr_clr = 0; ovr_set = 0;
`ifdef IMERSIV_SOFT_START_EN
    start = 0;
`endif
    if (rd) begin
      ent.d = m_read(a);
      ent.due = m_cyc + 2;
      rq.push_back(ent);
      if (a == 5'h1C) irq_clr = 1;
    end
    if (wr) begin
      if (a < 5'd28) begin
        if (m_busy()) ovr_set = 1;
        else begin
          m_rows[a] = d[27:0];
          m_written[a] = 1'b1;
        end
      end else if (a == 5'h1D) begin
        irq_clr = d[1];
        ovr_clr = d[2];
`ifdef IMERSIV_SOFT_START_EN
        start = d[0];
`endif
      end
    end
    if (m_phase == PH_OFFER) begin
      if (IMG_READY) m_phase = PH_INFER;
    end else if (m_phase == PH_INFER) begin
      if (CORE_DONE) begin
        m_result = CORE_CLASS;
        irq_set = 1;
        m_phase = PH_DONE;
      end
    end else begin
`ifdef IMERSIV_SOFT_START_EN
      if (start) begin
        if (m_full()) begin
          m_phase = PH_OFFER;
          for (int i = 0; i < NR; i++) m_written[i] = 1'b0;
        end else ovr_set = 1;
      end
`else
      if (m_full()) begin
        m_phase = PH_OFFER;
        for (int i = 0; i < NR; i++) m_written[i] = 1'b0;
      end
`endif
    end
    if (irq_set) m_irq = 1;
    else if (irq_clr) m_irq = 0;
    if (ovr_set) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
  endtask

  task automatic compare_model();
    checks++;
    if (IMG_VALID !== (m_phase == PH_OFFER)) begin
      errors++;
      $display("FAIL img_valid cyc=%0d got=%b want=%b", m_cyc, IMG_VALID, (m_phase == PH_OFFER));
    end
    checks++;
    if (CHARACTER_IRQ !== m_irq) begin
      errors++;
      $display("FAIL irq cyc=%0d got=%b want=%b", m_cyc, CHARACTER_IRQ, m_irq);
    end
    checks++;
    if (avl.AVL_READDATA !== m_rdata) begin
      errors++;
      $display("FAIL readdata cyc=%0d got=%h want=%h", m_cyc, avl.AVL_READDATA, m_rdata);
    end
    checks++;
    if (IMG_DATA !== m_img()) begin
      errors++;
      $display("FAIL img_data cyc=%0d got=%h want=%h", m_cyc, IMG_DATA, m_img());
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Advance one clock: model steps on the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge CLK);
    m_step();
    @(negedge CLK);
    compare_model();
    cycles++;
    if (cycles > 20000) begin
      $display("FAIL cycle_budget got=%0d want<=20000", cycles);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = a; avl.AVL_WRITEDATA = d;
    tick();
    avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
  endtask

  task automatic rd_lit(input string name, input logic [4:0] a, input logic [31:0] want);
    avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = a;
    tick();
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0;
    tick();
    tick();
    check_lit(name, avl.AVL_READDATA, want);
  endtask

  task automatic start_if_soft();
`ifdef IMERSIV_SOFT_START_EN
    wr(5'h1D, 32'h1);
`endif
  endtask

  initial begin
    logic [783:0] img;
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0; avl.AVL_WRITE = 1'b0;
    avl.AVL_ADDR = 5'h0; avl.AVL_WRITEDATA = 32'h0;
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    check_lit("reset_irq", {31'h0, CHARACTER_IRQ}, 32'h0);
    check_lit("reset_valid", {31'h0, IMG_VALID}, 32'h0);
    check_lit("reset_readdata", avl.AVL_READDATA, 32'h0);

    // 1: result then status, exactly two edges after the sample
    avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = 5'h1C;
    tick();
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0;
    tick();
    check_lit("rd_result_not_early", avl.AVL_READDATA, 32'h0);
    tick();
    check_lit("rd_result_reset", avl.AVL_READDATA, 32'h0000000F);
    avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = 5'h1D;
    tick();
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0;
    tick();
    check_lit("rd_status_not_early", avl.AVL_READDATA, 32'h0000000F);
    tick();
    check_lit("rd_status_reset", avl.AVL_READDATA, 32'h0);

    // start request with the mask empty
    wr(5'h1D, 32'h1);
`ifdef IMERSIV_SOFT_START_EN
    rd_lit("soft_start_not_full_ovr", 5'h1D, 32'h8);
`else
    rd_lit("start_bit_ignored", 5'h1D, 32'h0);
`endif
    wr(5'h1D, 32'h4);

    // 2: load rows, upper nibble ignored, duplicate row counts once
    IMG_READY = 1'b0;
    for (int i = 0; i < NR; i++) begin
      wr(5'(i), (i % 2 == 1) ? 32'hFAAAAAAA : 32'h0AAAAAAA);
      if (i == 10) wr(5'd5, 32'h0AAAAAAA);
      if (i == 26) check_lit("valid_before_last_row", {31'h0, IMG_VALID}, 32'h0);
    end
`ifdef IMERSIV_SOFT_START_EN
    check_lit("soft_no_autostart", {31'h0, IMG_VALID}, 32'h0);
    tick(); tick(); tick();
    rd_lit("soft_mask_full", 5'h1D, 32'h1);
    wr(5'h1D, 32'h1);
`endif
    check_lit("valid_after_load", {31'h0, IMG_VALID}, 32'h1);
    for (int k = 0; k < 5; k++) tick();
    check_lit("valid_held", {31'h0, IMG_VALID}, 32'h1);
    img = IMG_DATA;
    check_lit("row13_data", {4'h0, img[13*28 +: 28]}, 32'h0AAAAAAA);
    check_lit("row27_data", {4'h0, img[27*28 +: 28]}, 32'h0AAAAAAA);
    IMG_READY = 1'b1;
    tick();
    IMG_READY = 1'b0;
    check_lit("valid_drop_after_hs", {31'h0, IMG_VALID}, 32'h0);

    // 4: row write while busy is dropped and flags overrun
    wr(5'd3, 32'h00123456);
    rd_lit("row3_unchanged", 5'd3, 32'h0AAAAAAA);
    rd_lit("status_ovr_busy", 5'h1D, 32'hA);
    wr(5'h1D, 32'h4);
    rd_lit("status_ovr_cleared", 5'h1D, 32'h2);

    // 3: result latch and IRQ clear by result read
    CORE_CLASS = 4'd7; CORE_DONE = 1'b1;
    tick();
    CORE_DONE = 1'b0;
    check_lit("irq_set", {31'h0, CHARACTER_IRQ}, 32'h1);
    avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = 5'h1C;
    tick();
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0;
    check_lit("irq_clr_by_read", {31'h0, CHARACTER_IRQ}, 32'h0);
    tick(); tick();
    check_lit("result_7", avl.AVL_READDATA, 32'h00000007);
    rd_lit("status_done", 5'h1D, 32'h0);

    // pipelined back-to-back reads, then read+write collision
    for (int i = 0; i < 3; i++) begin
      avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = 5'(i);
      tick();
    end
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0;
    tick(); tick();
    check_lit("b2b_last", avl.AVL_READDATA, 32'h0AAAAAAA);
    avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_WRITE = 1'b1;
    avl.AVL_ADDR = 5'd0; avl.AVL_WRITEDATA = 32'h00000055;
    tick();
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0; avl.AVL_WRITE = 1'b0;
    tick(); tick();
    check_lit("rw_collision_read_dropped", avl.AVL_READDATA, 32'h0AAAAAAA);
    rd_lit("rw_collision_write_won", 5'd0, 32'h00000055);
    wr(5'h1E, 32'hFFFFFFFF);
    rd_lit("unmapped_reads_zero", 5'h1E, 32'h0);

    // 5: IRQ clear on the same edge as CORE_DONE; set wins
    IMG_READY = 1'b1;
    for (int i = 0; i < NR; i++) wr(5'(i), 32'h1 << i);
    start_if_soft();
    tick();
    img = IMG_DATA;
    check_lit("row0_walk", {4'h0, img[0 +: 28]}, 32'h00000001);
    check_lit("row27_walk", {4'h0, img[27*28 +: 28]}, 32'h08000000);
    CORE_CLASS = 4'd2; CORE_DONE = 1'b1;
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = 5'h1D; avl.AVL_WRITEDATA = 32'h2;
    tick();
    CORE_DONE = 1'b0; avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
    check_lit("irq_set_wins", {31'h0, CHARACTER_IRQ}, 32'h1);
    rd_lit("result_2", 5'h1C, 32'h00000002);

    // 6: reset mid-inference abandons the transaction
    for (int i = 0; i < NR; i++) wr(5'(i), 32'h05555555);
    start_if_soft();
    tick();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    IMG_READY = 1'b0;
    CORE_CLASS = 4'd9; CORE_DONE = 1'b1;
    tick();
    CORE_DONE = 1'b0;
    check_lit("irq_after_reset", {31'h0, CHARACTER_IRQ}, 32'h0);
    img = IMG_DATA;
    check_lit("row0_after_reset", {4'h0, img[0 +: 28]}, 32'h0);
    rd_lit("result_after_reset", 5'h1C, 32'h0000000F);
    rd_lit("status_after_reset", 5'h1D, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
